// File: rtl/multi_channel_memory_pkg.sv
// Shared types and defaults for the multi-channel fixed-latency memory model.
// Channel FSM encodings are fixed so waveforms stay readable across builds.
package memory_pkg;

  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_DATA_BITS    = 16;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_LATENCY      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAITING = 2'b10,
    READY   = 2'b11
  } chan_state_e;

  // Bit offset of channel `chan` inside a flat bus of `width`-bit slices.
  function automatic int slice_offset(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/memory_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module memory_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  int            gidx;

  // Priority is the rotated distance from the pointer; lowest distance wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    gidx        = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_valid && request[i] && (((i - int'(ptr) + N) % N) == k)) begin
          grant[i]    = 1'b1;
          grant_valid = 1'b1;
          gidx        = i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           ptr <= '0;
    else if (grant_valid) ptr <= PW'((gidx + 1) % N);
  end

endmodule

// File: rtl/multi_channel_memory.sv
// Multi-channel fixed-latency memory: parallel reads, writes serialized one
// per cycle through a round-robin arbiter against a single shared array.
module multi_channel_memory
  import memory_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int            DEPTH   = 1 << ADDR_BITS;
  localparam int            CW      = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_CNT = CW'(LATENCY);

  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic [NUM_CHANNELS-1:0] wr_eligible;
  logic [NUM_CHANNELS-1:0] wr_grant;
  logic                    wr_grant_valid;
  logic [ADDR_BITS-1:0]    wr_addr_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wr_data_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    commit_addr;
  logic [DATA_BITS-1:0]    commit_data;

  memory_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .request     (wr_eligible),
    .grant       (wr_grant),
    .grant_valid (wr_grant_valid)
  );

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      localparam int AO = slice_offset(c, ADDR_BITS);
      localparam int DO = slice_offset(c, DATA_BITS);

      chan_state_e          rd_state, wr_state;
      logic [CW-1:0]        rd_cnt, wr_cnt;
      logic [ADDR_BITS-1:0] rd_addr, wr_addr;
      logic [DATA_BITS-1:0] rd_data, wr_data;
      logic                 rd_ready, wr_ready;

      // Read loads see the array before this edge's commit (old data).
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_state <= IDLE;
          rd_cnt   <= '0;
          rd_addr  <= '0;
          rd_data  <= '0;
          rd_ready <= 1'b0;
        end else begin
          case (rd_state)
            IDLE: if (mem_read_valid[c]) begin
              rd_addr  <= mem_read_address[AO +: ADDR_BITS];
              rd_cnt   <= '0;
              rd_state <= WAITING;
            end
            WAITING: if (rd_cnt != LAT_CNT) begin
              rd_cnt <= rd_cnt + CW'(1);
            end else begin
              rd_data  <= mem[rd_addr];
              rd_ready <= 1'b1;
              rd_state <= READY;
            end
            READY: if (!mem_read_valid[c]) begin
              rd_ready <= 1'b0;
              rd_cnt   <= '0;
              rd_state <= IDLE;
            end
            default: rd_state <= IDLE;
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_state <= IDLE;
          wr_cnt   <= '0;
          wr_addr  <= '0;
          wr_data  <= '0;
          wr_ready <= 1'b0;
        end else begin
          case (wr_state)
            IDLE: if (mem_write_valid[c]) begin
              wr_addr  <= mem_write_address[AO +: ADDR_BITS];
              wr_data  <= mem_write_data[DO +: DATA_BITS];
              wr_cnt   <= '0;
              wr_state <= WAITING;
            end
            WAITING: if (wr_cnt != LAT_CNT) begin
              wr_cnt <= wr_cnt + CW'(1);
            end else if (wr_grant[c]) begin
              wr_ready <= 1'b1;
              wr_state <= READY;
            end
            READY: if (!mem_write_valid[c]) begin
              wr_ready <= 1'b0;
              wr_cnt   <= '0;
              wr_state <= IDLE;
            end
            default: wr_state <= IDLE;
          endcase
        end
      end

      assign wr_eligible[c]                = (wr_state == WAITING) && (wr_cnt == LAT_CNT);
      assign wr_addr_q[c]                  = wr_addr;
      assign wr_data_q[c]                  = wr_data;
      assign mem_read_ready[c]             = rd_ready;
      assign mem_read_data[DO +: DATA_BITS] = rd_data;
      assign mem_write_ready[c]            = wr_ready;
    end
  endgenerate

  always_comb begin
    commit_addr = '0;
    commit_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_grant[c]) begin
        commit_addr = wr_addr_q[c];
        commit_data = wr_data_q[c];
      end
    end
  end

  // Array is cleared on reset so a dropped transaction never leaves residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_grant_valid) begin
      mem[commit_addr] <= commit_data;
    end
  end

endmodule

// File: doc/multi_channel_memory.md
Name: multi_channel_memory

Overview:
- Parametrised, multi-channel, fixed-latency simulation memory model; successor to the single-channel 8-bit-address / 16-bit-data memory.
- Sits at the bottom of the GPU testbench. It serves NUM_CHANNELS independent valid/ready read and write channels, for example one per core memory controller, against one shared storage array.
- Reads are parallel on all channels. Writes commit one per cycle through a round-robin arbiter, giving deterministic ordering.

Parameters:
- ADDR_BITS, 8, address width; depth = 2**ADDR_BITS words.
- DATA_BITS, 16, word width.
- NUM_CHANNELS, 4, number of read channels and number of write channels (>=1).
- LATENCY, 3, cycles between request capture and data/commit eligibility (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request.
- mem_read_address  in  NUM_CHANNELS*ADDR_BITS  channel c occupies bits [c*ADDR_BITS +: ADDR_BITS].
- mem_read_ready  out  NUM_CHANNELS  per-channel read data valid.
- mem_read_data  out  NUM_CHANNELS*DATA_BITS  channel c at [c*DATA_BITS +: DATA_BITS].
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  NUM_CHANNELS*ADDR_BITS  packed as for reads.
- mem_write_data  in  NUM_CHANNELS*DATA_BITS  packed as for reads.
- mem_write_ready  out  NUM_CHANNELS  per-channel write committed.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low.
- Reset (reset=0, asynchronous):
  - all readies 0; all mem_read_data 0;
  - all channel FSMs IDLE; latency counters 0;
  - arbiter pointer 0; all memory words 0.
- Reset mid-transaction drops the transaction silently; no partial write lands. After release, channels resume from IDLE.
- Per-channel FSMs: each read and write channel has its own FSM with states IDLE, WAITING and READY, and its own counter of width $clog2(LATENCY+1).
- Read channel c:
  - IDLE: if valid[c], capture the address (edge E) and go to WAITING.
  - WAITING: increment the counter until it reaches LATENCY. On the next edge (E+LATENCY+1), load data[c] from memory, set ready[c]=1 and go to READY.
  - READY: data and ready hold while valid[c]=1. At the first edge with valid[c]=0: ready[c]=0, counter=0, go to IDLE. The data output keeps its last value.
  - A new request is captured no earlier than the edge after returning to IDLE.
- Write channel c:
  - IDLE: capture address and data on valid[c] (edge E).
  - WAITING: counter runs as for reads. The channel becomes commit-eligible from edge E+LATENCY+1.
  - Commit: at most one eligible channel commits per edge, chosen by the arbiter. At that edge the memory word is written, ready[c]=1, and the channel goes to READY.
  - Release from READY as for reads.
- Arbiter:
  - Round-robin over eligible write channels.
  - Search starts at the pointer, wraps modulo NUM_CHANNELS, and grants the first eligible channel.
  - On a grant, the pointer becomes (granted+1) mod NUM_CHANNELS. With no grant, the pointer holds.
- Same-edge read and write to one address: the read loads the pre-write value (old data).
- Multiple reads of one address on the same edge all get the same value.
- Two writes to one address commit on successive edges. The later grant's data persists.
- An input valid dropped while in WAITING is ignored: the transaction completes, and the channel returns to IDLE on the edge after it reaches READY.
- Addresses always fall inside the array (full decode); no out-of-range case exists.

Decomposition:
- Package memory_pkg holds:
  - state encodings IDLE=2'b00, WAITING=2'b10, READY=2'b11;
  - default parameter values;
  - a function giving the channel slice offset.
- Sub-module memory_rr_arbiter, parametrised by N:
  - inputs: request vector, clk, reset;
  - outputs: one-hot grant, grant_valid;
  - it holds the rotating pointer.
- The top module contains the storage array, the channel FSMs (generate loop) and the commit mux.

Test Plan:
All scenarios use defaults unless stated; the capture edge is E.
1. Single write then read:
   - ch0 writes 0xBEEF to 0x10, capture at E; ch0 write_ready rises at E+4.
   - Drop valid; ready falls on the next edge.
   - ch1 reads 0x10: read_ready rises 4 edges after capture with data 0xBEEF; both stay stable while valid is held.
2. Four-way write contention:
   - ch0..3 write 0xA0..0xA3 to 0x20..0x23 on the same edge.
   - write_ready rises on ch0, ch1, ch2, ch3 at E+4, E+5, E+6, E+7.
   - Readback returns the matching values; pointer ends at 0.
3. Fairness with the pointer at 1:
   - After ch0 alone completes a write, ch0 and ch2 request together.
   - ch2 is granted first, ch0 one cycle later.
4. Same-address conflict, then read-during-write:
   - ch0 writes 0x1111 and ch1 writes 0x2222 to 0x30 together; final content is 0x2222.
   - Then ch3 reads 0x30 aligned so its data load lands on the same edge as a 0x3333 write commit; the read returns 0x2222.
5. Mid-operation reset:
   - Assert reset=0 one cycle before a write to 0x40 (0x5555) would commit.
   - All readies go 0 immediately, without waiting for a clock edge.
   - After release, a read of 0x40 returns 0x0000 and new transactions complete normally.
6. Parameter sweep:
   - ADDR_BITS=10, DATA_BITS=32, NUM_CHANNELS=1, LATENCY=1.
   - Write 0xDEADBEEF to 0x3FF; write_ready rises at E+2.
   - Readback returns 0xDEADBEEF.
